// File: rtl/dual_port_memory.sv
// Purpose : synchronous RAM model, port A read/write with byte enables, port B read-only,
//           self-clearing after reset (init_busy high while every word is being zeroed).
// Latency : READ_LATENCY (1 or 2) cycles from the sampled request to dout/valid; streaming, no backpressure.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   init_busy                  high while the clear sequencer runs; requests are ignored then
//   a_en, a_rd_en, a_wr_en     port A enable and read/write requests
//   a_be, a_addr, a_din        port A byte-lane enables, word address, write data
//   a_dout, a_valid            port A read data and one-cycle completion strobe
//   b_en, b_addr               port B read request and word address
//   b_dout, b_valid            port B read data and one-cycle completion strobe
module dual_port_memory #(
    parameter int DATA_WIDTH   = 16,
    parameter int MEM_DEPTH    = 2**12,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_FIRST  = 0,
    localparam int ADDR_WIDTH  = $clog2(MEM_DEPTH),
    localparam int NB          = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_busy,
    input  logic                  a_en,
    input  logic                  a_rd_en,
    input  logic                  a_wr_en,
    input  logic [NB-1:0]         a_be,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_din,
    output logic [DATA_WIDTH-1:0] a_dout,
    output logic                  a_valid,
    input  logic                  b_en,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic [DATA_WIDTH-1:0] b_dout,
    output logic                  b_valid
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
    // One extra bit so the range compare also works when MEM_DEPTH is a power of two.
    localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  clr_we;
    logic                  clr_last;

    logic                  ready;
    logic                  a_in_range;
    logic                  b_in_range;
    logic                  a_rd_go;
    logic                  a_wr_go;
    logic                  b_rd_go;
    logic [DATA_WIDTH-1:0] a_old;
    logic [DATA_WIDTH-1:0] a_merged;
    logic [DATA_WIDTH-1:0] a_rd_word;
    logic [DATA_WIDTH-1:0] b_rd_word;

    logic                  a_vld_s1;
    logic                  b_vld_s1;
    logic [DATA_WIDTH-1:0] a_dat_s1;
    logic [DATA_WIDTH-1:0] b_dat_s1;

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    assign clr_last = (clr_addr == LAST_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CLEAR;
            clr_addr <= '0;
        end else begin
            state_q <= state_d;
            if (clr_we && !clr_last) begin
                clr_addr <= clr_addr + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        clr_we  = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we = !rst;
                if (clr_last) begin
                    state_d = READY;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    assign init_busy = (state_q == CLEAR);
    assign ready     = (state_q == READY) && !rst;

    // ------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------
    assign a_in_range = ({1'b0, a_addr} < DEPTH_L);
    assign b_in_range = ({1'b0, b_addr} < DEPTH_L);

    assign a_rd_go = ready && a_en && a_rd_en;
    assign a_wr_go = ready && a_en && a_wr_en && a_in_range;
    assign b_rd_go = ready && b_en;

    assign a_old = a_in_range ? mem[a_addr] : '0;

    // Word as it will look after this cycle's write: new bytes in enabled lanes.
    always_comb begin
        a_merged = a_old;
        for (int i = 0; i < NB; i++) begin
            if (a_wr_en && a_be[i]) begin
                a_merged[8*i +: 8] = a_din[8*i +: 8];
            end
        end
    end

    always_comb begin
        a_rd_word = a_old;
        if (!a_in_range) begin
            a_rd_word = '0;
        end else if (WRITE_FIRST != 0) begin
            a_rd_word = a_merged;
        end
    end

    // Port B samples the array before the port A write lands, so it always sees old data.
    assign b_rd_word = b_in_range ? mem[b_addr] : '0;

    // ------------------------------------------------------------------
    // Storage: the clear sequencer owns the array while busy
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (a_wr_go) begin
            for (int i = 0; i < NB; i++) begin
                if (a_be[i]) begin
                    mem[a_addr][8*i +: 8] <= a_din[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline, first stage. Data registers only load on a read so
    // the outputs hold their last value between completions.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_vld_s1 <= 1'b0;
            b_vld_s1 <= 1'b0;
            a_dat_s1 <= '0;
            b_dat_s1 <= '0;
        end else begin
            a_vld_s1 <= a_rd_go;
            b_vld_s1 <= b_rd_go;
            if (a_rd_go) begin
                a_dat_s1 <= a_rd_word;
            end
            if (b_rd_go) begin
                b_dat_s1 <= b_rd_word;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  a_vld_s2;
            logic                  b_vld_s2;
            logic [DATA_WIDTH-1:0] a_dat_s2;
            logic [DATA_WIDTH-1:0] b_dat_s2;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_vld_s2 <= 1'b0;
                    b_vld_s2 <= 1'b0;
                    a_dat_s2 <= '0;
                    b_dat_s2 <= '0;
                end else begin
                    a_vld_s2 <= a_vld_s1;
                    b_vld_s2 <= b_vld_s1;
                    if (a_vld_s1) begin
                        a_dat_s2 <= a_dat_s1;
                    end
                    if (b_vld_s1) begin
                        b_dat_s2 <= b_dat_s1;
                    end
                end
            end

            assign a_dout  = a_dat_s2;
            assign a_valid = a_vld_s2;
            assign b_dout  = b_dat_s2;
            assign b_valid = b_vld_s2;
        end else begin : g_lat1
            assign a_dout  = a_dat_s1;
            assign a_valid = a_vld_s1;
            assign b_dout  = b_dat_s1;
            assign b_valid = b_vld_s1;
        end
    endgenerate

endmodule

// File: tb/tb_dual_port_memory.sv
// Purpose : checks two memory configurations driven by the same stimulus:
//           dut0 32b x16, 2-cycle read, old-data collision; dut1 32b x12, 1-cycle read, new-data collision.
// Expected reads are queued with their arrival cycle when driven and popped when the DUT strobes valid.
module tb_dual_port_memory;

    typedef struct {
        logic [31:0] dat;
        int          arr;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        a_en;
    logic        a_rd_en;
    logic        a_wr_en;
    logic [3:0]  a_be;
    logic [3:0]  a_addr;
    logic [31:0] a_din;
    logic        b_en;
    logic [3:0]  b_addr;

    logic        busy0, busy1;
    logic [31:0] ad0, ad1, bd0, bd1;
    logic        av0, av1, bv0, bv1;

    exp_t        q [4][$];
    logic [31:0] m [2][16];
    logic [31:0] last [4];
    bit          mbusy [2];
    int          mcnt [2];
    int          cyc;
    int          checks;
    int          failures;

    dual_port_memory #(.DATA_WIDTH(32), .MEM_DEPTH(16), .READ_LATENCY(2), .WRITE_FIRST(0)) dut0 (
        .clk(clk), .rst(rst), .init_busy(busy0),
        .a_en(a_en), .a_rd_en(a_rd_en), .a_wr_en(a_wr_en), .a_be(a_be),
        .a_addr(a_addr), .a_din(a_din), .a_dout(ad0), .a_valid(av0),
        .b_en(b_en), .b_addr(b_addr), .b_dout(bd0), .b_valid(bv0)
    );

    dual_port_memory #(.DATA_WIDTH(32), .MEM_DEPTH(12), .READ_LATENCY(1), .WRITE_FIRST(1)) dut1 (
        .clk(clk), .rst(rst), .init_busy(busy1),
        .a_en(a_en), .a_rd_en(a_rd_en), .a_wr_en(a_wr_en), .a_be(a_be),
        .a_addr(a_addr), .a_din(a_din), .a_dout(ad1), .a_valid(av1),
        .b_en(b_en), .b_addr(b_addr), .b_dout(bd1), .b_valid(bv1)
    );

    function automatic int dep(int d);
        return (d == 0) ? 16 : 12;
    endfunction

    function automatic int lat(int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic bit wf(int d);
        return (d == 0) ? 1'b0 : 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference busy state and reset-time purge of reads that can no longer complete.
    always @(posedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                mbusy[d] = 1'b1;
                mcnt[d]  = dep(d);
            end else if (mbusy[d]) begin
                mcnt[d]--;
                if (mcnt[d] == 0) mbusy[d] = 1'b0;
            end
        end
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                last[i] = '0;
                while (q[i].size() > 0 && q[i][q[i].size()-1].arr >= cyc) void'(q[i].pop_back());
            end
        end
    end

    task automatic mon(input int i, input logic vld, input logic [31:0] dout);
        exp_t e;
        if (q[i].size() > 0 && q[i][0].arr < cyc) begin
            check($sformatf("missing_valid_p%0d", i), 32'(vld), 32'd1);
            void'(q[i].pop_front());
        end
        if (vld === 1'b1) begin
            if (q[i].size() == 0) begin
                check($sformatf("unexpected_valid_p%0d", i), 32'd1, 32'd0);
            end else begin
                e = q[i].pop_front();
                check($sformatf("read_data_p%0d", i), dout, e.dat);
                check($sformatf("read_cycle_p%0d", i), 32'(cyc), 32'(e.arr));
                last[i] = e.dat;
            end
        end else begin
            check($sformatf("valid_low_p%0d", i), 32'(vld), 32'd0);
            check($sformatf("dout_hold_p%0d", i), dout, last[i]);
        end
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("init_busy_d0", 32'(busy0), 32'(mbusy[0]));
            check("init_busy_d1", 32'(busy1), 32'(mbusy[1]));
            mon(0, av0, ad0);
            mon(1, bv0, bd0);
            mon(2, av1, ad1);
            mon(3, bv1, bd1);
        end
    end

    // Applies one cycle of stimulus and records what each memory must return.
    task automatic drive(input logic ae, input logic ard, input logic awr, input logic [3:0] be,
                         input logic [3:0] aa, input logic [31:0] ad, input logic bn, input logic [3:0] ba);
        logic [31:0] oldw;
        logic [31:0] mrg;
        logic [31:0] bw;
        exp_t        e;
        a_en = ae; a_rd_en = ard; a_wr_en = awr; a_be = be;
        a_addr = aa; a_din = ad; b_en = bn; b_addr = ba;
        for (int d = 0; d < 2; d++) begin
            if (!rst && !mbusy[d]) begin
                oldw = (int'(aa) < dep(d)) ? m[d][aa] : 32'h0;
                bw   = (int'(ba) < dep(d)) ? m[d][ba] : 32'h0;
                mrg  = oldw;
                for (int l = 0; l < 4; l++) begin
                    if (awr && be[l]) mrg[8*l +: 8] = ad[8*l +: 8];
                end
                if (ae && ard) begin
                    e.dat = (int'(aa) >= dep(d)) ? 32'h0 : (wf(d) ? mrg : oldw);
                    e.arr = cyc + lat(d);
                    q[2*d].push_back(e);
                end
                if (bn) begin
                    e.dat = bw;
                    e.arr = cyc + lat(d);
                    q[2*d+1].push_back(e);
                end
                if (ae && awr && int'(aa) < dep(d)) m[d][aa] = mrg;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 4'h0, 4'h0, 32'h0, 0, 4'h0);
    endtask

    task automatic do_reset(input int n);
        a_en = 0; a_rd_en = 0; a_wr_en = 0; b_en = 0;
        rst = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 16; w++) m[d][w] = 32'h0;
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 64 && (mbusy[0] || mbusy[1]); k++) idle(1);
    endtask

    task automatic sweep();
        for (int w = 0; w < 16; w++) drive(1, 1, 0, 4'h0, 4'(w), 32'h0, 1, 4'(15 - w));
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0;
        rst = 1'b1;
        a_en = 0; a_rd_en = 0; a_wr_en = 0; a_be = '0; a_addr = '0; a_din = '0; b_en = 0; b_addr = '0;
        for (int i = 0; i < 4; i++) last[i] = '0;
        for (int d = 0; d < 2; d++) begin
            mbusy[d] = 1'b1;
            mcnt[d]  = 0;
        end

        do_reset(3);
        wait_ready();

        // Garbage preload, then a one-cycle reset pulse with a write attempted while clearing.
        for (int w = 0; w < 16; w++) drive(1, 0, 1, 4'hF, 4'(w), $urandom, 0, 4'h0);
        do_reset(1);
        drive(1, 1, 1, 4'hF, 4'd2, 32'h0000FFFF, 1, 4'd2);
        wait_ready();
        sweep();
        idle(3);

        // Byte-lane merge.
        drive(1, 0, 1, 4'hF, 4'd5, 32'hDEADBEEF, 0, 4'h0);
        drive(1, 0, 1, 4'h5, 4'd5, 32'h11223344, 0, 4'h0);
        drive(1, 1, 0, 4'h0, 4'd5, 32'h0, 1, 4'd5);
        drive(1, 0, 1, 4'h0, 4'd5, 32'hFFFFFFFF, 0, 4'h0);
        drive(1, 1, 0, 4'h0, 4'd5, 32'h0, 0, 4'h0);
        idle(3);

        // Same-address collision on both ports.
        drive(1, 0, 1, 4'hF, 4'd3, 32'h00001234, 0, 4'h0);
        drive(1, 1, 1, 4'h3, 4'd3, 32'h0000ABCD, 1, 4'd3);
        drive(1, 1, 1, 4'h9, 4'd3, 32'h55667788, 1, 4'd3);
        drive(1, 1, 0, 4'h0, 4'd3, 32'h0, 1, 4'd3);
        idle(3);

        // Back-to-back streaming reads.
        for (int w = 0; w < 8; w++) drive(1, 0, 1, 4'hF, 4'(w), 32'h10 + 32'(w), 0, 4'h0);
        for (int w = 0; w < 8; w++) drive(1, 1, 0, 4'h0, 4'(7 - w), 32'h0, 1, 4'(w));
        idle(3);

        // Out-of-range addresses on the 12-word memory.
        for (int w = 10; w < 16; w++) drive(1, 1, 1, 4'hF, 4'(w), 32'hA0A0A000 + 32'(w), 1, 4'(w));
        sweep();
        idle(3);

        // Random traffic.
        for (int k = 0; k < 300; k++)
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom,
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        idle(3);

        // Reset one cycle after a read, then again part-way through the clear.
        drive(1, 1, 0, 4'h0, 4'd7, 32'h0, 1, 4'd6);
        do_reset(1);
        idle(5);
        do_reset(1);
        wait_ready();
        sweep();
        idle(4);

        for (int i = 0; i < 4; i++) check($sformatf("queue_drained_p%0d", i), 32'(q[i].size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dual_port_memory.md
# dual_port_memory

Parametrised successor to the single-port 16-bit bench memory: a synchronous RAM model with one read/write port (A) and one read-only port (B). It adds configurable width and depth, per-byte write enables, a 1- or 2-cycle read pipeline with valid strobes, a defined collision mode, and a self-clearing initialisation sequencer. It sits in the testbench as the program/data store for the DUT and for bench-side checkers that read memory concurrently.

## Interface
- DATA_WIDTH, 16: word width in bits; must be a multiple of 8.
- MEM_DEPTH, 2**12: number of words; any value ≥ 2.
- READ_LATENCY, 1: cycles from request to data; legal values are 1 and 2.
- WRITE_FIRST, 0: port-A same-address read+write returns new data (1) or old data (0).
- ADDR_WIDTH (localparam): $clog2(MEM_DEPTH).
- NB (localparam): DATA_WIDTH/8.

Ports:
- clk  in  1  single clock; all activity on the rising edge.
- rst  in  1  synchronous, active-high reset.
- init_busy  out  1  high while the memory is being cleared; requests are ignored.
- a_en  in  1  port A enable.
- a_rd_en  in  1  port A read request; qualified by a_en.
- a_wr_en  in  1  port A write request; qualified by a_en.
- a_be  in  NB  byte-lane write enables; bit i controls din[8i+7:8i].
- a_addr  in  ADDR_WIDTH  port A word address.
- a_din  in  DATA_WIDTH  port A write data.
- a_dout  out  DATA_WIDTH  port A read data.
- a_valid  out  1  one-cycle strobe; a_dout is valid in that cycle.
- b_en  in  1  port B read request.
- b_addr  in  ADDR_WIDTH  port B word address.
- b_dout  out  DATA_WIDTH  port B read data.
- b_valid  out  1  one-cycle strobe; b_dout is valid in that cycle.

## Operation
- FSM states:
  - CLEAR: entered on any edge with rst=1. clr_addr is set to 0.
  - CLEAR (rst=0): each cycle writes word clr_addr to all zeros, then increments clr_addr.
  - CLEAR to READY: the transition happens after word MEM_DEPTH-1 is written.
  - READY: normal operation.
- init_busy is 1 exactly when the state is CLEAR.
- Reset values: init_busy=1, a_dout=0, b_dout=0, a_valid=0, b_valid=0, all pipeline stages=0.
- Reset mid-clear or mid-operation: the clear restarts at address 0 and in-flight reads are discarded (their valids are never asserted).
- Requests during CLEAR are ignored: no write occurs and no valid is asserted.
- Port A write (READY, a_en & a_wr_en):
  - Only lanes with a_be[i]=1 are updated.
  - a_be=0 performs no write.
- Port A read (READY, a_en & a_rd_en): returns the word at a_addr.
- Port A simultaneous read and write to the same address:
  - WRITE_FIRST=0: returns the pre-write word.
  - WRITE_FIRST=1: returns the merged word (new bytes in enabled lanes, old bytes elsewhere).
- Port B read (READY, b_en): always returns the pre-write word when port A writes the same address in the same cycle.
- a_dout and b_dout hold their last value when no read completes.
- Addresses are used unmodified. MEM_DEPTH that is not a power of two with an out-of-range address: the write is dropped and the read returns 0.

## Timing
- READ_LATENCY=1: request at edge N; data and valid are visible after edge N+1, i.e. in cycle N+1.
- READ_LATENCY=2: data and valid appear one cycle later, through an extra output register.
- A write is visible to any read requested at a later edge.
- Both ports accept a new request every cycle; the pipeline is fully streaming with no backpressure.
- Clear duration: rst is sampled high on the last reset edge. init_busy then stays high for exactly MEM_DEPTH cycles after rst falls. The first request can be accepted on the edge where init_busy reads 0.

## Test plan
- Clear:
  - Stimulus: MEM_DEPTH=16, preload garbage, pulse rst 1 cycle.
  - Required: init_busy high for 16 cycles after rst falls; then reads of all addresses return 0.
- Byte enables:
  - Stimulus: DATA_WIDTH=32, write 0xDEADBEEF with be=4'b1111 at address 5, then 0x11223344 with be=4'b0101.
  - Required: read of address 5 returns 0xDE22BE44.
- Collision:
  - Stimulus: address 3 holds 0x1234. In one cycle, port A writes 0xABCD (be=2'b11) with a_rd_en=1, and port B reads address 3.
  - Required: b_dout=0x1234. a_dout=0x1234 with WRITE_FIRST=0; a_dout=0xABCD with WRITE_FIRST=1.
- Latency and streaming:
  - Stimulus: READ_LATENCY=2; back-to-back port-B reads of addresses 0..7 holding values 0x10..0x17.
  - Required: b_valid high for 8 consecutive cycles, starting 2 cycles after the first request; data 0x10..0x17 in order.
- Reset mid-read:
  - Stimulus: READ_LATENCY=2; assert rst one cycle after a port-A read.
  - Required: a_valid never asserted; a_dout=0; clear restarts at address 0.
- Requests while busy:
  - Stimulus: write 0xFFFF to address 2 during CLEAR.
  - Required: no valid asserted; address 2 reads 0 after READY.
